// File: rtl/instruction_loader.sv
// Instruction loader: assembles a little-endian byte stream into 32-bit words
// and writes them to instruction memory through a one-cycle write strobe.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for start; outputs quiet
// COLLECT | byte_ready high, accepting bytes into lanes 0..3
// WRITE   | write_enable high for one cycle with address/data valid
// FINISH  | done pulse for one cycle, then back to IDLE
module instruction_loader #(
  parameter int unsigned DEPTH     = 2048,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [9:0]  word_count,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        write_enable,
  output logic [31:0] address_inst_mem,
  output logic [31:0] data_input,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
    S_FINISH
  } state_t;

  // Compared in 33 bits so a word near the top of the 32-bit space cannot wrap.
  localparam logic [32:0] LAST_BYTE = 33'(DEPTH) - 33'd1;

  state_t      state;
  logic [9:0]  count_latched;
  logic [9:0]  word_idx;
  logic [1:0]  byte_idx;
  logic [23:0] lane_buf;
  logic [31:0] next_addr;
  logic        overflow;
  logic        last_word;

  // Word at next_addr would extend past the end of the memory.
  assign overflow  = ({1'b0, next_addr} + 33'd3) > LAST_BYTE;
  assign last_word = (word_idx + 10'd1) == count_latched;

  // Single sequencing process; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= S_IDLE;
      byte_ready       <= 1'b0;
      write_enable     <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      error            <= 1'b0;
      address_inst_mem <= BASE_ADDR;
      data_input       <= 32'h0;
      byte_idx         <= 2'd0;
      word_idx         <= 10'd0;
      count_latched    <= 10'd0;
      next_addr        <= BASE_ADDR;
      lane_buf         <= 24'h0;
    end else begin
      write_enable <= 1'b0;
      done         <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            count_latched    <= word_count;
            next_addr        <= BASE_ADDR;
            address_inst_mem <= BASE_ADDR;
            byte_idx         <= 2'd0;
            word_idx         <= 10'd0;
            error            <= 1'b0;
            busy             <= 1'b1;
            if (word_count == 10'd0) begin
              state <= S_FINISH;
              done  <= 1'b1;
            end else begin
              state      <= S_COLLECT;
              byte_ready <= 1'b1;
            end
          end
        end
        S_COLLECT: begin
          if (byte_valid && byte_ready) begin
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0:    lane_buf[7:0]   <= byte_data;
              2'd1:    lane_buf[15:8]  <= byte_data;
              2'd2:    lane_buf[23:16] <= byte_data;
              default: lane_buf        <= lane_buf;
            endcase
            if (byte_idx == 2'd3) begin
              byte_ready <= 1'b0;
              // Out-of-range word: no strobe, flag it and end the session.
              if (overflow) begin
                error <= 1'b1;
                done  <= 1'b1;
                state <= S_FINISH;
              end else begin
                write_enable     <= 1'b1;
                address_inst_mem <= next_addr;
                data_input       <= {byte_data, lane_buf};
                state            <= S_WRITE;
              end
            end
          end
        end
        S_WRITE: begin
          // address_inst_mem keeps the written address; next_addr tracks the following word.
          next_addr <= next_addr + 32'd4;
          word_idx  <= word_idx + 10'd1;
          if (last_word) begin
            state <= S_FINISH;
            done  <= 1'b1;
          end else begin
            state      <= S_COLLECT;
            byte_ready <= 1'b1;
          end
        end
        S_FINISH: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state      <= S_IDLE;
          busy       <= 1'b0;
          byte_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/instruction_loader.md
INSTRUCTION_LOADER -- requirements
Module: instruction_loader

Interface
REQ-001 Parameter DEPTH, default 2048: size of the target instruction memory in bytes.
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000: byte address of the first word written.
REQ-003 clk  input  1  single clock for all sequential logic.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 start  input  1  one-cycle request to begin a load session; sampled only in IDLE.
REQ-006 word_count  input  10  number of 32-bit words in the session; sampled when start is accepted.
REQ-007 byte_valid  input  1  source presents a byte on byte_data.
REQ-008 byte_data  input  8  incoming program byte, least-significant byte of each word first.
REQ-009 byte_ready  output  1  loader accepts a byte this cycle; transfer occurs when byte_valid && byte_ready.
REQ-010 write_enable  output  1  one-cycle write strobe to the instruction memory.
REQ-011 address_inst_mem  output  32  byte address of the word being written.
REQ-012 data_input  output  32  assembled word to write, byte0 in [7:0] through byte3 in [31:24].
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse at session end.
REQ-015 error  output  1  sticky flag set on address overflow; cleared by reset or the next accepted start.

Function
REQ-016 All outputs shall be registered and update on the rising edge of clk, so they are stable at the memory's falling-edge write.
REQ-017 FSM states: IDLE, COLLECT, WRITE, FINISH.
REQ-018 IDLE: on start=1, latch word_count, set address to BASE_ADDR, clear the byte index and word counter, and clear error; go to FINISH if word_count==0, otherwise go to COLLECT.
REQ-019 start shall be ignored in every state other than IDLE.
REQ-020 byte_ready shall be 1 only in COLLECT.
REQ-021 COLLECT: each accepted byte shall be placed in lane byte_index; byte_index increments mod 4.
REQ-022 COLLECT: acceptance of the 4th byte (index 3) shall transition to WRITE on the next edge.
REQ-023 byte_valid while byte_ready=0 shall have no effect, and the byte is not consumed.
REQ-024 WRITE: write_enable=1 for exactly one cycle, with address_inst_mem and data_input held valid for that same cycle.
REQ-025 Leaving WRITE: address increments by 4 and the word counter increments by 1.
REQ-026 Leaving WRITE: go to FINISH if word counter+1 == latched count, otherwise go to COLLECT.
REQ-027 Overflow check: on entry to WRITE, if address_inst_mem+3 > DEPTH-1, suppress write_enable, set error, and go to FINISH.
REQ-028 Latency: the write strobe shall occur in the cycle after the 4th byte is accepted.
REQ-029 Minimum spacing: the 4 accept cycles plus 1 write cycle give 5 cycles per word.
REQ-030 FINISH: done=1 for one cycle, then go to IDLE.
REQ-031 FINISH: address_inst_mem and data_input shall hold their last values.
REQ-032 The word counter shall be 10 bits wide, covering a maximum of 1023 words (more than DEPTH/4 at the default DEPTH); address arithmetic is 32-bit with no wrap-around, and the overflow check governs.
REQ-033 write_enable shall be 0 in every state other than WRITE.

Reset
REQ-034 On reset=1: state=IDLE.
REQ-035 On reset=1: byte_ready=0, write_enable=0, busy=0, done=0, error=0.
REQ-036 On reset=1: address_inst_mem=BASE_ADDR, data_input=0, byte index=0, word counter=0.
REQ-037 Reset mid-session shall abort immediately: no further writes occur and partially collected bytes are discarded.
REQ-038 Reset shall take priority over start and over byte transfers in the same cycle.

Verification
REQ-039 start, word_count=1, bytes 13,00,00,00 with byte_valid held high -> a single write_enable pulse with address 0 and data 32'h0000_0013, then done one cycle later.
REQ-040 word_count=3 with continuous bytes -> writes at addresses 0, 4 and 8, 5 cycles apart, data correctly byte-ordered, then done.
REQ-041 byte_valid toggled randomly with gaps -> identical memory image, no dropped or duplicated bytes, and byte_ready=0 during WRITE.
REQ-042 start with word_count=0 -> busy for one cycle, done pulse, no write_enable.
REQ-043 DEPTH=16, word_count=5 -> 4 writes (addresses 0 to 12), the 5th write suppressed, error=1, done pulse.
REQ-044 reset asserted after 2 bytes of word 2 -> no write for word 2, all outputs at reset values; a new session after reset starts at BASE_ADDR.
